// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the programmable clock divider.
package clkdiv_pkg;

    // Working width of the helper functions; callers cast to their own widths.
    localparam int unsigned FN_W    = 32;
    localparam int unsigned MIN_DIV = 2;

    // Smallest usable divisor is 2; anything below is raised to it.
    function automatic logic [FN_W-1:0] clamp_div(input logic [FN_W-1:0] value);
        return (value < FN_W'(MIN_DIV)) ? FN_W'(MIN_DIV) : value;
    endfunction

    // First count value of the high phase: D - D/2 (odd D gets the longer low phase).
    function automatic logic [FN_W-1:0] high_start(input logic [FN_W-1:0] d);
        return d - (d >> 1);
    endfunction

endpackage

// File: rtl/clkdiv_counter.sv
// Mod-D period counter with enable, wrap flag and next-count look-ahead.
module clkdiv_counter
    import clkdiv_pkg::*;
#(
    parameter int unsigned CNT_W = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [CNT_W-1:0] div,
    output logic [CNT_W-1:0] count_next_c,
    output logic             wrap_c
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] last;

    // Next count: hold when disabled, wrap to 0 at D-1 (>= guards against stale values).
    always_comb begin
        last    = div - CNT_W'(1);
        wrap_c  = 1'b0;
        count_d = count_q;
        if (enable) begin
            if (count_q >= last) begin
                wrap_c  = 1'b1;
                count_d = '0;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
        count_next_c = count_d;
    end

    // Period count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/clk_divider_prog.sv
// Programmable glitch-free clock divider: square wave, per-period tick and
// run-time divisor reload that only takes effect at a period boundary.
// Optional tick counter enabled by defining CLKDIV_TICK_CNT_EN.
module clk_divider_prog
    import clkdiv_pkg::*;
#(
    parameter int unsigned CNT_W       = 26,
    parameter int unsigned DEFAULT_DIV = 50000000,
    parameter int unsigned TICK_CNT_W  = 16
) (
    input  logic                  clock_50,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [CNT_W-1:0]      div_value,
    input  logic                  div_load,
    output logic                  novo_clock,
    output logic                  tick,
    output logic [CNT_W-1:0]      div_active,
    output logic                  load_pending
`ifdef CLKDIV_TICK_CNT_EN
    ,
    output logic [TICK_CNT_W-1:0] tick_count
`endif
);

    logic [CNT_W-1:0] count_next;
    logic             wrap;
    logic             apply;

    logic [CNT_W-1:0] div_active_q, div_active_d;
    logic [CNT_W-1:0] pending_q, pending_d;
    logic             load_pending_q, load_pending_d;
    logic             novo_clock_q, novo_clock_d;
    logic             tick_q, tick_d;

    // Period counter runs on the divisor currently in use.
    clkdiv_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk          (clock_50),
        .rst_n        (reset),
        .enable       (enable),
        .div          (div_active_q),
        .count_next_c (count_next),
        .wrap_c       (wrap)
    );

    // Load capture, boundary-only apply and output decode from the next count.
    always_comb begin
        pending_d      = pending_q;
        load_pending_d = load_pending_q;
        div_active_d   = div_active_q;
        apply          = wrap && load_pending_q;
        if (apply) begin
            div_active_d   = pending_q;
            load_pending_d = 1'b0;
        end
        // A load on the wrap cycle lands after the apply, so it waits a period.
        if (div_load) begin
            pending_d      = CNT_W'(clamp_div(FN_W'(div_value)));
            load_pending_d = 1'b1;
        end
        novo_clock_d = (FN_W'(count_next) >= high_start(FN_W'(div_active_d)));
        tick_d       = enable && (count_next == (div_active_d - CNT_W'(1)));
    end

    // Divider state and registered outputs.
    always_ff @(posedge clock_50 or negedge reset) begin
        if (!reset) begin
            div_active_q   <= CNT_W'(DEFAULT_DIV);
            pending_q      <= '0;
            load_pending_q <= 1'b0;
            novo_clock_q   <= 1'b0;
            tick_q         <= 1'b0;
        end else begin
            div_active_q   <= div_active_d;
            pending_q      <= pending_d;
            load_pending_q <= load_pending_d;
            novo_clock_q   <= novo_clock_d;
            tick_q         <= tick_d;
        end
    end

    assign novo_clock   = novo_clock_q;
    assign tick         = tick_q;
    assign div_active   = div_active_q;
    assign load_pending = load_pending_q;

`ifdef CLKDIV_TICK_CNT_EN
    logic [TICK_CNT_W-1:0] tick_count_q, tick_count_d;

    // Count ticks, wrapping naturally at the counter width.
    always_comb begin
        tick_count_d = tick_count_q;
        if (tick_d) begin
            tick_count_d = tick_count_q + TICK_CNT_W'(1);
        end
    end

    // Tick counter register.
    always_ff @(posedge clock_50 or negedge reset) begin
        if (!reset) begin
            tick_count_q <= '0;
        end else begin
            tick_count_q <= tick_count_d;
        end
    end

    assign tick_count = tick_count_q;
`endif

endmodule

// File: tb/tb_clk_divider_prog.sv
// Scoreboard bench for clk_divider_prog (CNT_W=8, DEFAULT_DIV=4).
module tb_clk_divider_prog;

    localparam int unsigned CNT_W      = 8;
    localparam int unsigned TICK_CNT_W = 16;

    logic             clock_50 = 1'b0;
    logic             reset    = 1'b0;
    logic             enable   = 1'b0;
    logic [CNT_W-1:0] div_value = '0;
    logic             div_load = 1'b0;
    logic             novo_clock;
    logic             tick;
    logic [CNT_W-1:0] div_active;
    logic             load_pending;
`ifdef CLKDIV_TICK_CNT_EN
    logic [TICK_CNT_W-1:0] tick_count;
`endif

    typedef struct {
        logic       novo;
        logic       tck;
        logic [7:0] div;
        logic       pend;
        int         idx;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   step_idx = 0;

    clk_divider_prog #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (4),
        .TICK_CNT_W  (TICK_CNT_W)
    ) dut (
        .clock_50     (clock_50),
        .reset        (reset),
        .enable       (enable),
        .div_value    (div_value),
        .div_load     (div_load),
        .novo_clock   (novo_clock),
        .tick         (tick),
        .div_active   (div_active),
        .load_pending (load_pending)
`ifdef CLKDIV_TICK_CNT_EN
        ,
        .tick_count   (tick_count)
`endif
    );

    always #10 clock_50 = ~clock_50;

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s step=%0d actual=%0h required=%0h", name, idx, act, req);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    // pos = count after that edge, d = active divisor after that edge.
    task automatic step(input logic en, input logic ld, input logic [7:0] val,
                        input int pos, input int d, input logic pend);
        exp_t e;
        @(negedge clock_50);
        #1;
        reset     = 1'b1;
        enable    = en;
        div_load  = ld;
        div_value = val;
        step_idx++;
        e.novo = (pos >= d - d / 2);
        e.tck  = en && (pos == d - 1);
        e.div  = 8'(d);
        e.pend = pend;
        e.idx  = step_idx;
        exp_q.push_back(e);
    endtask

    // Assert reset; expect reset values at the next sample.
    task automatic do_reset();
        exp_t e;
        @(negedge clock_50);
        #1;
        reset    = 1'b0;
        enable   = 1'b0;
        div_load = 1'b0;
        step_idx++;
        e.novo = 1'b0;
        e.tck  = 1'b0;
        e.div  = 8'd4;
        e.pend = 1'b0;
        e.idx  = step_idx;
        exp_q.push_back(e);
    endtask

    // Monitor: compare DUT outputs against the queued expectation each cycle.
    always @(negedge clock_50) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("novo_clock",   e.idx, 32'(novo_clock),   32'(e.novo));
            check("tick",         e.idx, 32'(tick),         32'(e.tck));
            check("div_active",   e.idx, 32'(div_active),   32'(e.div));
            check("load_pending", e.idx, 32'(load_pending), 32'(e.pend));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset state.
        do_reset();
        do_reset();

        // Default divisor 4: novo 0,0,1,1 with tick at count 3.
        for (int i = 1; i <= 9; i++) step(1, 0, 8'd0, i % 4, 4, 0);

        // Load 6 at count 1: current period finishes at 4, then 6.
        step(1, 1, 8'd6, 2, 4, 1);
        step(1, 0, 8'd0, 3, 4, 1);
        step(1, 0, 8'd0, 0, 6, 0);
        for (int p = 1; p <= 5; p++) step(1, 0, 8'd0, p, 6, 0);
        step(1, 0, 8'd0, 0, 6, 0);

        // Odd divisor 5: low 3, high 2.
        step(1, 1, 8'd5, 1, 6, 1);
        for (int p = 2; p <= 5; p++) step(1, 0, 8'd0, p, 6, 1);
        step(1, 0, 8'd0, 0, 5, 0);
        for (int p = 1; p <= 4; p++) step(1, 0, 8'd0, p, 5, 0);
        step(1, 0, 8'd0, 0, 5, 0);

        // Load 0 clamps to 2: novo toggles, tick every 2nd cycle.
        step(1, 1, 8'd0, 1, 5, 1);
        for (int p = 2; p <= 4; p++) step(1, 0, 8'd0, p, 5, 1);
        step(1, 0, 8'd0, 0, 2, 0);
        for (int i = 1; i <= 4; i++) step(1, 0, 8'd0, i % 2, 2, 0);
        // Load 1 also clamps to 2.
        step(1, 1, 8'd1, 1, 2, 1);
        step(1, 0, 8'd0, 0, 2, 0);
        step(1, 0, 8'd0, 1, 2, 0);

        // Load 7 on the wrap cycle: applied one period later.
        step(1, 1, 8'd7, 0, 2, 1);
        step(1, 0, 8'd0, 1, 2, 1);
        step(1, 0, 8'd0, 0, 7, 0);
        for (int p = 1; p <= 6; p++) step(1, 0, 8'd0, p, 7, 0);
        step(1, 0, 8'd0, 0, 7, 0);

        // Pending 3, then load 4 on the wrap: wrap applies 3, 4 stays pending.
        step(1, 1, 8'd3, 1, 7, 1);
        for (int p = 2; p <= 6; p++) step(1, 0, 8'd0, p, 7, 1);
        step(1, 1, 8'd4, 0, 3, 1);
        step(1, 0, 8'd0, 1, 3, 1);
        step(1, 0, 8'd0, 2, 3, 1);
        step(1, 0, 8'd0, 0, 4, 0);

        // Two loads before the wrap: last one wins.
        step(1, 1, 8'd9, 1, 4, 1);
        step(1, 1, 8'd5, 2, 4, 1);
        step(1, 0, 8'd0, 3, 4, 1);
        step(1, 0, 8'd0, 0, 5, 0);

        // Freeze at count 4 (D=5) for 10 cycles; a load is still captured.
        for (int p = 1; p <= 4; p++) step(1, 0, 8'd0, p, 5, 0);
        for (int i = 0; i < 10; i++) step(0, (i == 2), 8'd8, 4, 5, (i >= 2));
        step(1, 0, 8'd0, 0, 8, 0);
        step(1, 0, 8'd0, 1, 8, 0);
        step(1, 0, 8'd0, 2, 8, 0);

        // Reset mid-period with a load pending: pending value is discarded.
        step(1, 1, 8'd3, 3, 8, 1);
        do_reset();
        for (int i = 1; i <= 5; i++) step(1, 0, 8'd0, i % 4, 4, 0);

        @(negedge clock_50);
        #1;
        check("queue_drained", step_idx, 32'(exp_q.size()), 32'd0);
`ifdef CLKDIV_TICK_CNT_EN
        // Only the count-3 tick occurred since the last reset.
        check("tick_count", step_idx, 32'(tick_count), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
